// File: rtl/wbu_uart_pkg.sv
// rtl/wbu_uart_pkg.sv - shared state encoding and framing constants for the 8N1 transmitter
package wbu_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [23:0] DEFAULT_CLOCKS_PER_BAUD = 24'd868;
    localparam int          BITS_PER_FRAME          = 10;

endpackage

// File: rtl/wbu_baud_tick.sv
// rtl/wbu_baud_tick.sv - reloadable bit-period down-counter with end-of-bit and next-to-last flags
module wbu_baud_tick #(
    parameter int                LGBAUD          = 24,
    parameter logic [LGBAUD-1:0] CLOCKS_PER_BAUD = LGBAUD'(868)
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_reload,
    input  logic i_enable,
    output logic o_tick,
    output logic o_near_end
);

    logic [LGBAUD-1:0] counter_q;
    logic [LGBAUD-1:0] counter_d;

    // Reload wins over decrement; the count parks at zero until reloaded.
    always_comb begin
        counter_d = counter_q;
        if (i_reload) begin
            counter_d = CLOCKS_PER_BAUD - LGBAUD'(1);
        end else if (i_enable && (counter_q != '0)) begin
            counter_d = counter_q - LGBAUD'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            counter_q <= '0;
        end else begin
            counter_q <= counter_d;
        end
    end

    assign o_tick     = (counter_q == '0);
    assign o_near_end = (counter_q == LGBAUD'(1));

endmodule

// File: rtl/wbu_uart_tx.sv
// rtl/wbu_uart_tx.sv - 8N1 UART transmitter with zero-gap back-to-back frames
// Optional WBU_UART_TX_CTS_EN adds i_cts_n flow control gating frame starts.
module wbu_uart_tx
    import wbu_uart_pkg::*;
#(
    parameter int                LGBAUD          = 24,
    parameter logic [LGBAUD-1:0] CLOCKS_PER_BAUD = LGBAUD'(DEFAULT_CLOCKS_PER_BAUD)
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_stb,
    input  logic [7:0] i_data,
`ifdef WBU_UART_TX_CTS_EN
    input  logic       i_cts_n,
`endif
    output logic       o_busy,
    output logic       o_uart_tx
);

    localparam int DATA_BITS = BITS_PER_FRAME - 2;

    uart_state_t state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic        busy_q;
    logic        tx_q;

    logic        tick;
    logic        near_end;
    logic        accept;
    logic        reload;
    logic        cts_block;
    logic        cts_next;

`ifdef WBU_UART_TX_CTS_EN
    logic cts_meta_q;
    logic cts_sync_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cts_meta_q <= 1'b0;
            cts_sync_q <= 1'b0;
        end else begin
            cts_meta_q <= i_cts_n;
            cts_sync_q <= cts_meta_q;
        end
    end

    // Busy tracks the value about to enter the sync stage, so it clears
    // the same edge the synchroniser output does and a start follows one clock later.
    assign cts_block = cts_sync_q;
    assign cts_next  = cts_meta_q;
`else
    assign cts_block = 1'b0;
    assign cts_next  = 1'b0;
`endif

    assign accept = i_stb && !busy_q && !cts_block &&
                    ((state_q == IDLE) || ((state_q == STOP) && tick));
    assign reload = accept || (tick && ((state_q == START) || (state_q == DATA)));

    wbu_baud_tick #(
        .LGBAUD         (LGBAUD),
        .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
    ) u_baud (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_reload  (reload),
        .i_enable  (state_q != IDLE),
        .o_tick    (tick),
        .o_near_end(near_end)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            shift_q   <= 8'h00;
            bit_idx_q <= 3'd0;
            busy_q    <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= START;
                        shift_q <= i_data;
                        busy_q  <= 1'b1;
                        tx_q    <= 1'b0;
                    end else begin
                        busy_q  <= cts_next;
                    end
                end
                START: begin
                    if (tick) begin
                        state_q   <= DATA;
                        bit_idx_q <= 3'd0;
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        // Last stop-bit clock doubles as the next frame's acceptance edge.
                        if (accept) begin
                            state_q <= START;
                            shift_q <= i_data;
                            busy_q  <= 1'b1;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= cts_next;
                        end
                    end else if (near_end) begin
                        busy_q <= cts_next;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign o_busy    = busy_q;
    assign o_uart_tx = tx_q;

endmodule
